draw_channel_bars: RTL
======================

// Module: draw_channel_bars
// PURPOSE
//  Downstream overlay stage of the VGA pipeline: consumes the registered timing bus (vcount/hcount,
//  sync, blank, rgb) from the timing delay stage and draws CHANNELS vertical voltage bars over rgb.
//  Bar heights come from a write port fed by the ADC sampler. Values are double-buffered: a shadow
//  bank is written at any time, and the active bank is refreshed only at vblank start (no tearing).
// PARAMETERS
//  CHANNELS   13        number of bars/channels (1..16)
//  BAR_X0     64        hcount of first pixel of bar 0
//  BAR_W      40        bar width in pixels
//  BAR_GAP    16        gap between bars; pitch = BAR_W+BAR_GAP
//  BAR_BASE_Y 700       vcount of bottom row of every bar
//  VAL_SHIFT  3         height_px = wr_data >> VAL_SHIFT (4095 -> 511)
//  BAR_COLOR  12'h0_F_0 rgb of bar pixels
// PORTS
//  pclk       in   1   pixel clock
//  rst        in   1   synchronous, active-high reset
//  vcount_in/hcount_in in 12  pixel counters;  vsync_in,vblnk_in,hsync_in,hblnk_in in 1;  rgb_in in 12
//  wr_valid   in   1   channel value write request
//  wr_ready   out  1   write accepted when wr_valid&&wr_ready
//  wr_ch      in   4   channel index of write
//  wr_data    in   12  raw ADC value (unsigned)
//  vcount_out/hcount_out out 12; vsync_out,vblnk_out,hsync_out,hblnk_out out 1; rgb_out out 12
// BEHAVIOUR
//  - Reset: all outputs 0, wr_ready 0, shadow and active banks cleared to 0, FSM -> IDLE.
//  - Latency: every output is its input delayed exactly 2 pclk (stage S1, S2); rgb possibly replaced.
//  - Column tracker (S1, no dividers): when hcount_in==BAR_X0 -> active=1, ch=0, pos=0; else if active:
//    pos++, at pos==BAR_W+BAR_GAP-1 pos wraps to 0 and ch++; wrap with ch==CHANNELS-1 -> active=0.
//    S1 registers in_bar = active && pos<BAR_W, and ch.
//  - S2: h = active_bank[ch] >> VAL_SHIFT; draw = in_bar && vcount_d1<=BAR_BASE_Y
//    && vcount_d1 > BAR_BASE_Y-h (signed compare, 13 bits). h==0 draws nothing.
//  - rgb_out = (draw && !hblnk_d1 && !vblnk_d1) ? BAR_COLOR : rgb_d1.
//  - Write port: wr_ch<CHANNELS -> shadow[wr_ch]<=wr_data; wr_ch>=CHANNELS accepted and discarded.
//    wr_ready registered: 1 in IDLE, 0 in COPY and during rst.
//  - FSM IDLE/COPY: vblnk rise = vblnk_in && !vblnk_in_prev. IDLE & rise -> COPY, idx=0, wr_ready<=0.
//    COPY: active[idx]<=shadow[idx], idx++; after idx==CHANNELS-1 -> IDLE, wr_ready<=1 (CHANNELS cycles).
//  - Write accepted in the rise-detect cycle is visible in that copy. A rise seen during COPY is ignored.
//  - Active bank changes only during COPY (vblank), so a frame never mixes old and new heights.
//  - rst mid-COPY: abort, banks cleared, IDLE; next copy only on next vblnk rise.
// TESTING (1024x768 timing, default parameters)
//  1 rst held 5 cycles -> all outputs 0, wr_ready 0; wr_ready 1 one cycle after release.
//  2 write ch0=4095, run 2 frames -> bar 0 rows 190..700, cols 64..103 BAR_COLOR; row 189/col 104 = rgb_in.
//  3 write ch12=800 (h=100) -> cols 736..775, rows 601..700 BAR_COLOR; hcount 776 passthrough.
//  4 write ch3=2048 mid-frame (vcount 300) -> unchanged this frame; bar of 256 px from next frame on.
//  5 wr_valid held from vblnk rise -> wr_ready low 13 cycles, write accepted after; wr_ch=13 -> no change.
//  6 rst asserted mid-COPY -> banks 0, no bars drawn; all timing outputs equal inputs delayed 2 cycles.

Source files
------------

// File: rtl/draw_channel_bars_if.sv
// rtl/draw_channel_bars_if.sv - registered VGA timing bus (counters, syncs, blanks, rgb)
interface draw_channel_bars_if;
    logic [11:0] vcount;
    logic [11:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport slave  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_channel_bars.sv
// rtl/draw_channel_bars.sv - two-stage overlay drawing CHANNELS vertical bars on the timing bus
// Bar heights are double-buffered: shadow bank written any time, active bank refreshed at vblank start.
module draw_channel_bars #(
    parameter int unsigned CHANNELS   = 13,
    parameter int unsigned BAR_X0     = 64,
    parameter int unsigned BAR_W      = 40,
    parameter int unsigned BAR_GAP    = 16,
    parameter int unsigned BAR_BASE_Y = 700,
    parameter int unsigned VAL_SHIFT  = 3,
    parameter logic [11:0] BAR_COLOR  = 12'h0F0
) (
    input  logic                pclk,
    input  logic                rst,
    draw_channel_bars_if.slave  vid_i,
    draw_channel_bars_if.master vid_o,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [3:0]          wr_ch_i,
    input  logic [11:0]         wr_data_i
);
    localparam int unsigned PITCH = BAR_W + BAR_GAP;

    typedef enum logic {IDLE, COPY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        wr_ready_q, ready_d;
    logic        vblnk_prev_q;
    logic        copy_en;
    logic [11:0] shadow_q [CHANNELS];
    logic [11:0] active_q [CHANNELS];

    logic        trk_act_q, trk_act_d;
    logic [3:0]  trk_ch_q, trk_ch_d;
    logic [11:0] trk_pos_q, trk_pos_d;
    logic        in_bar_q;
    logic [3:0]  bar_ch_q;

    logic [11:0] vcount_d1_q, hcount_d1_q, rgb_d1_q;
    logic        vsync_d1_q, vblnk_d1_q, hsync_d1_q, hblnk_d1_q;
    logic [11:0] out_vcount_q, out_hcount_q, out_rgb_q;
    logic        out_vsync_q, out_vblnk_q, out_hsync_q, out_hblnk_q;

    logic [11:0] h_px;
    logic [12:0] bar_top;
    logic        draw;

    // Column tracker walks the bar pitch with a counter so no divider is needed per pixel.
    always_comb begin
        trk_act_d = trk_act_q;
        trk_ch_d  = trk_ch_q;
        trk_pos_d = trk_pos_q;
        if (vid_i.hcount == 12'(BAR_X0)) begin
            trk_act_d = 1'b1;
            trk_ch_d  = '0;
            trk_pos_d = '0;
        end else if (trk_act_q) begin
            if (trk_pos_q == 12'(PITCH - 1)) begin
                trk_pos_d = '0;
                if (trk_ch_q == 4'(CHANNELS - 1)) trk_act_d = 1'b0;
                else                              trk_ch_d  = trk_ch_q + 4'd1;
            end else begin
                trk_pos_d = trk_pos_q + 12'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            trk_act_q   <= 1'b0;
            trk_ch_q    <= '0;
            trk_pos_q   <= '0;
            in_bar_q    <= 1'b0;
            bar_ch_q    <= '0;
            vcount_d1_q <= '0;
            hcount_d1_q <= '0;
            rgb_d1_q    <= '0;
            vsync_d1_q  <= 1'b0;
            vblnk_d1_q  <= 1'b0;
            hsync_d1_q  <= 1'b0;
            hblnk_d1_q  <= 1'b0;
        end else begin
            trk_act_q   <= trk_act_d;
            trk_ch_q    <= trk_ch_d;
            trk_pos_q   <= trk_pos_d;
            in_bar_q    <= trk_act_d && (trk_pos_d < 12'(BAR_W));
            bar_ch_q    <= trk_ch_d;
            vcount_d1_q <= vid_i.vcount;
            hcount_d1_q <= vid_i.hcount;
            rgb_d1_q    <= vid_i.rgb;
            vsync_d1_q  <= vid_i.vsync;
            vblnk_d1_q  <= vid_i.vblnk;
            hsync_d1_q  <= vid_i.hsync;
            hblnk_d1_q  <= vid_i.hblnk;
        end
    end

    // Signed 13-bit top row so tall bars (h > BAR_BASE_Y) cannot wrap around.
    always_comb begin
        h_px    = 12'(active_q[bar_ch_q] >> VAL_SHIFT);
        bar_top = 13'(BAR_BASE_Y) - {1'b0, h_px};
        draw    = in_bar_q && (vcount_d1_q <= 12'(BAR_BASE_Y))
                  && ($signed({1'b0, vcount_d1_q}) > $signed(bar_top));
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            out_vcount_q <= '0;
            out_hcount_q <= '0;
            out_rgb_q    <= '0;
            out_vsync_q  <= 1'b0;
            out_vblnk_q  <= 1'b0;
            out_hsync_q  <= 1'b0;
            out_hblnk_q  <= 1'b0;
        end else begin
            out_vcount_q <= vcount_d1_q;
            out_hcount_q <= hcount_d1_q;
            out_rgb_q    <= (draw && !hblnk_d1_q && !vblnk_d1_q) ? BAR_COLOR : rgb_d1_q;
            out_vsync_q  <= vsync_d1_q;
            out_vblnk_q  <= vblnk_d1_q;
            out_hsync_q  <= hsync_d1_q;
            out_hblnk_q  <= hblnk_d1_q;
        end
    end

    assign vid_o.vcount = out_vcount_q;
    assign vid_o.hcount = out_hcount_q;
    assign vid_o.rgb    = out_rgb_q;
    assign vid_o.vsync  = out_vsync_q;
    assign vid_o.vblnk  = out_vblnk_q;
    assign vid_o.hsync  = out_hsync_q;
    assign vid_o.hblnk  = out_hblnk_q;
    assign wr_ready_o   = wr_ready_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        copy_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (vid_i.vblnk && !vblnk_prev_q) begin
                    state_d = COPY;
                    idx_d   = '0;
                end
            end
            COPY: begin
                copy_en = 1'b1;
                idx_d   = idx_q + 4'd1;
                if (idx_q == 4'(CHANNELS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // vblnk_prev resets high so a vblank already in progress at reset release is not a new frame.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wr_ready_q   <= 1'b0;
            vblnk_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_ready_q   <= ready_d;
            vblnk_prev_q <= vid_i.vblnk;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wr_valid_i && wr_ready_q && ({1'b0, wr_ch_i} < 5'(CHANNELS)))
                shadow_q[wr_ch_i] <= wr_data_i;
            if (copy_en)
                active_q[idx_q] <= shadow_q[idx_q];
        end
    end
endmodule
